// File: rtl/memory_controller_if.sv
// MFA/MOC handshake bundle between the control unit and main memory.
// The master drives requests; the slave (memory) returns data and status.
interface memory_controller_if;
  logic        MFA;
  logic        RW;
  logic [1:0]  Type;
  logic        SignExt;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Busy;
  logic        Error;

  modport master (
    output MFA, RW, Type, SignExt, Address, DataIn,
    input  DataOut, MOC, Busy, Error
  );

  modport slave (
    input  MFA, RW, Type, SignExt, Address, DataIn,
    output DataOut, MOC, Busy, Error
  );
endinterface

// File: rtl/memory_controller.sv
// Byte-addressed big-endian main memory with MFA/MOC handshake,
// programmable latency and misalignment/reserved-type flagging.
module memory_controller #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  memory_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rw_q;
  logic              sext_q;
  logic [1:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [7:0]        mem [2**ADDR_W];

  logic [ADDR_W-1:0] a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic              bad;
  logic              fire;
  logic              wr_en;
  logic [31:0]       rdata;
  logic              unused_addr;

  assign unused_addr = ^bus.Address[31:ADDR_W];

  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);
  assign b0 = mem[addr_q];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  assign bad = (type_q == 2'b11)
             | ((type_q == 2'b01) & addr_q[0])
             | ((type_q == 2'b10) & (|addr_q[1:0]));
  assign fire  = (state == WAIT) && (cnt == 4'd0);
  // Reset gating keeps an aborted write from touching the array
  assign wr_en = fire & ~rw_q & ~bad & ~reset;

  always_comb begin
    rdata = 32'h0;
    case (type_q)
      2'b00:   rdata = {{24{sext_q & b0[7]}}, b0};
      2'b01:   rdata = {{16{sext_q & b0[7]}}, b0, b1};
      2'b10:   rdata = {b0, b1, b2, b3};
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (type_q)
        2'b00: mem[addr_q] <= din_q[7:0];
        2'b01: begin
          mem[addr_q] <= din_q[15:8];
          mem[a1]     <= din_q[7:0];
        end
        2'b10: begin
          mem[addr_q] <= din_q[31:24];
          mem[a1]     <= din_q[23:16];
          mem[a2]     <= din_q[15:8];
          mem[a3]     <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      rw_q        <= 1'b1;
      sext_q      <= 1'b0;
      type_q      <= 2'b00;
      addr_q      <= '0;
      din_q       <= 32'h0;
      bus.MOC     <= 1'b0;
      bus.Busy    <= 1'b0;
      bus.Error   <= 1'b0;
      bus.DataOut <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.MFA) begin
            rw_q     <= bus.RW;
            type_q   <= bus.Type;
            sext_q   <= bus.SignExt;
            addr_q   <= bus.Address[ADDR_W-1:0];
            din_q    <= bus.DataIn;
            cnt      <= 4'(LATENCY);
            bus.Busy <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.MOC   <= 1'b1;
            bus.Error <= bad;
            if (bad)
              bus.DataOut <= 32'h0;
            else if (rw_q)
              bus.DataOut <= rdata;
            state <= DONE;
          end
        end
        DONE: begin
          if (!bus.MFA) begin
            bus.MOC   <= 1'b0;
            bus.Busy  <= 1'b0;
            bus.Error <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: two instances (latency 2 and 0)
// checked every cycle against a byte-array reference model.
module tb_memory_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mfa = 1'b0;
  logic        sel = 1'b0;
  logic        rw = 1'b1;
  logic        sext = 1'b0;
  logic [1:0]  typ = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic        exp_moc  [2];
  logic        exp_busy [2];
  logic        exp_err  [2];
  logic [31:0] exp_data [2];
  logic [7:0]  mm [2][256];

  logic [31:0] dv;
  logic        de;

  memory_controller_if bus_a ();
  memory_controller_if bus_b ();

  assign bus_a.MFA     = mfa & ~sel;
  assign bus_a.RW      = rw;
  assign bus_a.Type    = typ;
  assign bus_a.SignExt = sext;
  assign bus_a.Address = addr;
  assign bus_a.DataIn  = din;
  assign bus_b.MFA     = mfa & sel;
  assign bus_b.RW      = rw;
  assign bus_b.Type    = typ;
  assign bus_b.SignExt = sext;
  assign bus_b.Address = addr;
  assign bus_b.DataIn  = din;

  memory_controller #(.ADDR_W(8), .LATENCY(2)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  memory_controller #(.ADDR_W(8), .LATENCY(0)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h need %h", name, act, req);
    end
  endtask

  function automatic logic is_bad(input logic [1:0] t, input logic [31:0] a);
    return (t == 2'd3) || (t == 2'd1 && a % 2 != 0) || (t == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] rd(input int s, input logic [1:0] t,
                                     input logic sx, input logic [31:0] a);
    int b;
    int v;
    b = int'(a % 256);
    v = 0;
    case (t)
      2'd0: begin
        v = int'(mm[s][b]);
        if (sx && v >= 128) v -= 256;
      end
      2'd1: begin
        v = int'(mm[s][b]) * 256 + int'(mm[s][(b + 1) % 256]);
        if (sx && v >= 32768) v -= 65536;
      end
      default:
        return {mm[s][b], mm[s][(b + 1) % 256], mm[s][(b + 2) % 256],
                mm[s][(b + 3) % 256]};
    endcase
    return 32'(v);
  endfunction

  task automatic mwr(input int s, input logic [1:0] t, input logic [31:0] a,
                     input logic [31:0] d);
    int b;
    int n;
    b = int'(a % 256);
    n = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++)
      mm[s][(b + i) % 256] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("a_moc",  32'(bus_a.MOC),  32'(exp_moc[0]));
      cmp("a_busy", 32'(bus_a.Busy), 32'(exp_busy[0]));
      cmp("a_data", bus_a.DataOut,   exp_data[0]);
      if (exp_moc[0]) cmp("a_err", 32'(bus_a.Error), 32'(exp_err[0]));
      cmp("b_moc",  32'(bus_b.MOC),  32'(exp_moc[1]));
      cmp("b_busy", 32'(bus_b.Busy), 32'(exp_busy[1]));
      cmp("b_data", bus_b.DataOut,   exp_data[1]);
      if (exp_moc[1]) cmp("b_err", 32'(bus_b.Error), 32'(exp_err[1]));
    end
  end

  // One full request; inputs are scrambled after acceptance on purpose
  task automatic run(input int s, input logic w_rw, input logic [1:0] t,
                     input logic sx, input logic [31:0] a, input logic [31:0] d,
                     input int hold, input bit drop,
                     output logic [31:0] dout, output logic derr);
    int   lat;
    logic bad;
    lat = (s == 0) ? 2 : 0;
    bad = is_bad(t, a);
    @(negedge clk);
    sel = s[0]; rw = w_rw; typ = t; sext = sx; addr = a; din = d; mfa = 1'b1;
    @(posedge clk); #1;
    exp_busy[s] = 1'b1;
    rw = ~rw; typ = ~typ; sext = ~sext; addr = addr ^ 32'h6; din = ~din;
    if (drop) mfa = 1'b0;
    repeat (lat) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    exp_moc[s] = 1'b1;
    exp_err[s] = bad;
    if (bad) exp_data[s] = 32'h0;
    else if (w_rw) exp_data[s] = rd(s, t, sx, a);
    else mwr(s, t, a, d);
    dout = (s == 0) ? bus_a.DataOut : bus_b.DataOut;
    derr = (s == 0) ? bus_a.Error : bus_b.Error;
    repeat (hold) begin @(posedge clk); #1; end
    mfa = 1'b0;
    @(posedge clk); #1;
    exp_moc[s]  = 1'b0;
    exp_busy[s] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      exp_moc[s] = 1'b0; exp_busy[s] = 1'b0;
      exp_err[s] = 1'b0; exp_data[s] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_moc",  32'(bus_a.MOC),   32'h0);
    cmp("rst_busy", 32'(bus_a.Busy),  32'h0);
    cmp("rst_err",  32'(bus_a.Error), 32'h0);
    cmp("rst_data", bus_a.DataOut,    32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;

    run(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, dv, de);
    cmp("wr_err", 32'(de), 32'h0);
    run(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, dv, de);
    cmp("rd_word", dv, 32'hDEADBEEF);
    run(0, 1'b1, 2'd0, 1'b0, 32'h10, 32'h0, 0, 1'b0, dv, de);
    cmp("rd_byte", dv, 32'h000000DE);

    run(0, 1'b0, 2'd0, 1'b0, 32'h20, 32'h00000080, 0, 1'b0, dv, de);
    run(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h00000001, 0, 1'b0, dv, de);
    run(0, 1'b1, 2'd1, 1'b1, 32'h20, 32'h0, 0, 1'b0, dv, de);
    cmp("ldrsh", dv, 32'hFFFF8001);
    run(0, 1'b1, 2'd1, 1'b0, 32'h20, 32'h0, 0, 1'b0, dv, de);
    cmp("ldrh", dv, 32'h00008001);
    run(0, 1'b1, 2'd0, 1'b1, 32'h21, 32'h0, 0, 1'b0, dv, de);
    cmp("ldrsb_pos", dv, 32'h00000001);
    run(0, 1'b1, 2'd0, 1'b1, 32'h20, 32'h0, 0, 1'b0, dv, de);
    cmp("ldrsb_neg", dv, 32'hFFFFFF80);

    run(0, 1'b0, 2'd2, 1'b0, 32'h13, 32'h11111111, 0, 1'b0, dv, de);
    cmp("mis_wr_err", 32'(de), 32'h1);
    run(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, dv, de);
    cmp("mis_wr_keep", dv, 32'hDEADBEEF);
    run(0, 1'b1, 2'd1, 1'b1, 32'h21, 32'h0, 0, 1'b0, dv, de);
    cmp("mis_rd_err", 32'(de), 32'h1);
    cmp("mis_rd_data", dv, 32'h0);
    run(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0, 0, 1'b0, dv, de);
    cmp("rsv_err", 32'(de), 32'h1);

    run(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 5, 1'b0, dv, de);
    cmp("hold_data", dv, 32'hDEADBEEF);
    run(0, 1'b1, 2'd1, 1'b1, 32'h20, 32'h0, 0, 1'b1, dv, de);
    cmp("drop_data", dv, 32'hFFFF8001);

    run(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0000CAFE, 0, 1'b0, dv, de);
    run(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 0, 1'b0, dv, de);
    cmp("half_wr", dv, 32'h8001CAFE);

    run(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'hA5A50F0F, 0, 1'b0, dv, de);
    @(negedge clk);
    sel = 1'b0; rw = 1'b0; typ = 2'd2; sext = 1'b0;
    addr = 32'h30; din = 32'h12345678; mfa = 1'b1;
    @(posedge clk); #1;
    exp_busy[0] = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1;
    exp_moc[0] = 1'b0; exp_busy[0] = 1'b0; exp_data[0] = 32'h0;
    exp_moc[1] = 1'b0; exp_busy[1] = 1'b0; exp_data[1] = 32'h0;
    #1;
    cmp("mid_rst_moc",  32'(bus_a.MOC),  32'h0);
    cmp("mid_rst_busy", 32'(bus_a.Busy), 32'h0);
    mfa = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    run(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 0, 1'b0, dv, de);
    cmp("mid_rst_keep", dv, 32'hA5A50F0F);

    run(1, 1'b0, 2'd2, 1'b0, 32'h00000104, 32'h11223344, 0, 1'b0, dv, de);
    run(1, 1'b1, 2'd2, 1'b0, 32'h04, 32'h0, 0, 1'b0, dv, de);
    cmp("wrap_word", dv, 32'h11223344);
    run(1, 1'b1, 2'd0, 1'b0, 32'h07, 32'h0, 2, 1'b0, dv, de);
    cmp("wrap_byte", dv, 32'h00000044);

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
